// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - SAP-1 controller-sequencer shared types and constants
//
// Purpose: opcode constants, the one-hot T-state type and the packed control word
// shared by the ring counter and the controller-sequencer top level.
// Ports: none (package).

package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // One-hot ring position, bit0 = T1.
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_t;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_bar;
        logic ce_bar;
        logic li_bar;
        logic ei_bar;
        logic la_bar;
        logic ea;
        logic su;
        logic eu;
        logic lb_bar;
        logic lo_bar;
    } control_word_t;

    // Nothing driven onto the W-bus, nothing loaded.
    localparam control_word_t IDLE_CW = '{
        cp:     1'b0,
        ep:     1'b0,
        lm_bar: 1'b1,
        ce_bar: 1'b1,
        li_bar: 1'b1,
        ei_bar: 1'b1,
        la_bar: 1'b1,
        ea:     1'b0,
        su:     1'b0,
        eu:     1'b0,
        lb_bar: 1'b1,
        lo_bar: 1'b1
    };

endpackage

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - one-hot rotating T-state counter with hold
//
// Purpose: rotates a single set bit T1 -> T2 -> ... -> Tn -> T1 on each falling
// clock edge; hold_i freezes the current position.
// Ports:
//   clk_i       - clock, state changes on the falling edge
//   clr_bar_i   - synchronous active-low clear, forces T1, wins over hold
//   hold_i      - freeze the ring at its current position
//   t_state_o   - one-hot position, bit0 = T1

module ring_counter #(
    parameter int LENGTH = 6
) (
    input  logic              clk_i,
    input  logic              clr_bar_i,
    input  logic              hold_i,
    output logic [LENGTH-1:0] t_state_o
);

    localparam logic [LENGTH-1:0] FIRST = {{(LENGTH-1){1'b0}}, 1'b1};

    logic [LENGTH-1:0] state_q;
    logic [LENGTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (!hold_i) begin
            state_d = {state_q[LENGTH-2:0], state_q[LENGTH-1]};
        end
    end

    // Falling edge so the decoded control word is settled at the rising edge
    // where the datapath registers load.
    always_ff @(negedge clk_i) begin
        if (!clr_bar_i) begin
            state_q <= FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    assign t_state_o = state_q;

endmodule

// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP-1 controller-sequencer (ring counter, decode, halt)
//
// Purpose: sequences T1..T6 and decodes the opcode into the SAP-1 control word;
// halts on HLT with the ring frozen at T4 until reset.
// Ports:
//   clk             - system clock, state updates on the falling edge
//   clr_bar         - synchronous active-low reset
//   instruction_bus - opcode from the instruction register
//   t_state         - one-hot ring counter, bit0 = T1
//   hlt             - high while halted
//   Cp .. Lo_bar    - control word (active-high and _bar active-low lines)

module controller_sequencer
    import sap1_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = 4,
    parameter int RING_LENGTH       = 6
) (
    input  logic                         clk,
    input  logic                         clr_bar,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_bus,
    output logic [RING_LENGTH-1:0]       t_state,
    output logic                         hlt,
    output logic                         Cp,
    output logic                         Ep,
    output logic                         Lm_bar,
    output logic                         CE_bar,
    output logic                         Li_bar,
    output logic                         Ei_bar,
    output logic                         La_bar,
    output logic                         Ea,
    output logic                         Su,
    output logic                         Eu,
    output logic                         Lb_bar,
    output logic                         Lo_bar
);

    logic          hlt_q;
    logic          hlt_d;
    control_word_t cw;

    // The halt flag itself is the hold: on the edge that enters halt the flag is
    // still low, so the ring makes its last step T3 -> T4 in the same update.
    ring_counter #(
        .LENGTH (RING_LENGTH)
    ) u_ring (
        .clk_i     (clk),
        .clr_bar_i (clr_bar),
        .hold_i    (hlt_q),
        .t_state_o (t_state)
    );

    always_comb begin
        hlt_d = hlt_q;
        if ((t_state == T3) && (instruction_bus == OP_HLT)) begin
            hlt_d = 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (!clr_bar) begin
            hlt_q <= 1'b0;
        end else begin
            hlt_q <= hlt_d;
        end
    end

    // While halted the word is idle no matter what sits on the bus.
    always_comb begin
        cw = IDLE_CW;
        if (!hlt_q) begin
            case (t_state)
                T1: begin
                    cw.ep     = 1'b1;
                    cw.lm_bar = 1'b0;
                end
                T2: begin
                    cw.cp = 1'b1;
                end
                T3: begin
                    cw.ce_bar = 1'b0;
                    cw.li_bar = 1'b0;
                end
                T4: begin
                    case (instruction_bus)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw.lm_bar = 1'b0;
                            cw.ei_bar = 1'b0;
                        end
                        OP_OUT: begin
                            cw.ea     = 1'b1;
                            cw.lo_bar = 1'b0;
                        end
                        default: cw = IDLE_CW;
                    endcase
                end
                T5: begin
                    case (instruction_bus)
                        OP_LDA: begin
                            cw.ce_bar = 1'b0;
                            cw.la_bar = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            cw.ce_bar = 1'b0;
                            cw.lb_bar = 1'b0;
                        end
                        default: cw = IDLE_CW;
                    endcase
                end
                T6: begin
                    case (instruction_bus)
                        OP_ADD, OP_SUB: begin
                            cw.la_bar = 1'b0;
                            cw.eu     = 1'b1;
                            cw.su     = (instruction_bus == OP_SUB);
                        end
                        default: cw = IDLE_CW;
                    endcase
                end
                default: cw = IDLE_CW;
            endcase
        end
    end

    assign hlt    = hlt_q;
    assign Cp     = cw.cp;
    assign Ep     = cw.ep;
    assign Lm_bar = cw.lm_bar;
    assign CE_bar = cw.ce_bar;
    assign Li_bar = cw.li_bar;
    assign Ei_bar = cw.ei_bar;
    assign La_bar = cw.la_bar;
    assign Ea     = cw.ea;
    assign Su     = cw.su;
    assign Eu     = cw.eu;
    assign Lb_bar = cw.lb_bar;
    assign Lo_bar = cw.lo_bar;

endmodule

// File: tb/tb_controller_sequencer.sv
// tb/tb_controller_sequencer.sv - directed scoreboard bench for controller_sequencer

module tb_controller_sequencer;

    // Control word bit positions: {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
    localparam int B_CP = 11;
    localparam int B_EP = 10;
    localparam int B_LM = 9;
    localparam int B_CE = 8;
    localparam int B_LI = 7;
    localparam int B_EI = 6;
    localparam int B_LA = 5;
    localparam int B_EA = 4;
    localparam int B_SU = 3;
    localparam int B_EU = 2;
    localparam int B_LB = 1;
    localparam int B_LO = 0;
    localparam logic [11:0] IDLE = 12'b0011_1110_0011;

    typedef struct {
        string       tag;
        logic [5:0]  ts;
        logic        h;
        logic [11:0] cw;
    } exp_t;

    logic       clk;
    logic       clr_bar;
    logic [3:0] instruction_bus;
    logic [5:0] t_state;
    logic       hlt;
    logic       Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar;

    exp_t sb[$];
    int   m_t;
    logic m_h;
    int   errors;
    int   checks;

    controller_sequencer #(
        .INSTRUCTION_WIDTH (4),
        .RING_LENGTH       (6)
    ) dut (
        .clk             (clk),
        .clr_bar         (clr_bar),
        .instruction_bus (instruction_bus),
        .t_state         (t_state),
        .hlt             (hlt),
        .Cp              (Cp),
        .Ep              (Ep),
        .Lm_bar          (Lm_bar),
        .CE_bar          (CE_bar),
        .Li_bar          (Li_bar),
        .Ei_bar          (Ei_bar),
        .La_bar          (La_bar),
        .Ea              (Ea),
        .Su              (Su),
        .Eu              (Eu),
        .Lb_bar          (Lb_bar),
        .Lo_bar          (Lo_bar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] exp_cw(input int t, input logic h, input logic [3:0] op);
        logic [11:0] w;
        w = IDLE;
        if (!h) begin
            case (t)
                1: begin w[B_EP] = 1'b1; w[B_LM] = 1'b0; end
                2: w[B_CP] = 1'b1;
                3: begin w[B_CE] = 1'b0; w[B_LI] = 1'b0; end
                4: begin
                    if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
                        w[B_LM] = 1'b0; w[B_EI] = 1'b0;
                    end else if (op == 4'hE) begin
                        w[B_EA] = 1'b1; w[B_LO] = 1'b0;
                    end
                end
                5: begin
                    if (op == 4'h0) begin
                        w[B_CE] = 1'b0; w[B_LA] = 1'b0;
                    end else if (op == 4'h1 || op == 4'h2) begin
                        w[B_CE] = 1'b0; w[B_LB] = 1'b0;
                    end
                end
                6: begin
                    if (op == 4'h1 || op == 4'h2) begin
                        w[B_LA] = 1'b0; w[B_EU] = 1'b1;
                        w[B_SU] = (op == 4'h2);
                    end
                end
                default: w = IDLE;
            endcase
        end
        return w;
    endfunction

    task automatic check_pop();
        exp_t        e;
        logic [11:0] obs_cw;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_empty: observed size %0d, expected nonzero", sb.size());
        end
        if (sb.size() > 0) begin
            e      = sb.pop_front();
            obs_cw = {Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar};
            checks++;
            assert (t_state === e.ts) else begin
                errors++;
                $error("FAIL %s t_state: observed %b expected %b", e.tag, t_state, e.ts);
            end
            checks++;
            assert (hlt === e.h) else begin
                errors++;
                $error("FAIL %s hlt: observed %b expected %b", e.tag, hlt, e.h);
            end
            checks++;
            assert (obs_cw === e.cw) else begin
                errors++;
                $error("FAIL %s cw: observed %b expected %b", e.tag, obs_cw, e.cw);
            end
        end
    endtask

    // Drive inputs just after a rising edge, advance the reference model for the
    // coming falling edge, then compare just after that falling edge.
    task automatic cycle(input logic clr, input logic [3:0] op, input string tag);
        exp_t e;
        clr_bar         = clr;
        instruction_bus = op;
        if (!clr) begin
            m_t = 1;
            m_h = 1'b0;
        end else if (!m_h) begin
            if (m_t == 3 && op == 4'hF) begin
                m_t = 4;
                m_h = 1'b1;
            end else begin
                m_t = (m_t == 6) ? 1 : m_t + 1;
            end
        end
        e.tag = tag;
        e.ts  = 6'b000001 << (m_t - 1);
        e.h   = m_h;
        e.cw  = exp_cw(m_t, m_h, op);
        sb.push_back(e);
        @(negedge clk);
        #1;
        check_pop();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ops [5];
        errors          = 0;
        checks          = 0;
        m_t             = 1;
        m_h             = 1'b0;
        clr_bar         = 1'b0;
        instruction_bus = 4'h0;
        ops[0] = 4'h0;
        ops[1] = 4'h2;
        ops[2] = 4'h1;
        ops[3] = 4'hE;
        ops[4] = 4'h5;
        @(posedge clk);
        #1;

        cycle(1'b0, 4'h0, "reset0");
        cycle(1'b0, 4'h0, "reset1");

        for (int k = 0; k < 5; k++) begin
            for (int s = 0; s < 6; s++) begin
                cycle(1'b1, ops[k], $sformatf("op%h_s%0d", ops[k], s));
            end
        end

        for (int s = 0; s < 3; s++) begin
            cycle(1'b1, 4'hF, $sformatf("hlt_enter%0d", s));
        end
        for (int s = 0; s < 20; s++) begin
            cycle(1'b1, (s % 2 == 1) ? 4'h1 : 4'hE, $sformatf("halted%0d", s));
        end
        cycle(1'b0, 4'h3, "hlt_reset");

        for (int s = 0; s < 4; s++) begin
            cycle(1'b1, 4'h1, $sformatf("add_pre%0d", s));
        end
        cycle(1'b0, 4'h1, "mid_add_reset");
        for (int s = 0; s < 6; s++) begin
            cycle(1'b1, 4'h1, $sformatf("add_post%0d", s));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
